// File: rtl/alu_operand_stage.sv
// ============================================================================
// alu_operand_stage : MIPS ALU operand decode/issue stage, valid/ready output
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_operand_stage #(
  parameter int SKID = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [5:0]  out_aluc,
  output logic [4:0]  out_dest,
  output logic        out_wen,
  output logic        out_illegal
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  aluc;
    logic [4:0]  dest;
    logic        wen;
    logic        illegal;
  } payload_t;

  localparam payload_t c_reset_pl = '{
    a: 32'd0, b: 32'd0, aluc: 6'b100001, dest: 5'd0, wen: 1'b0, illegal: 1'b0
  };

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_shamt;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_sx;
  logic [31:0] w_imm_zx;
  logic        w_unused_rs;
  payload_t    w_dec;
  logic        w_accept;

  payload_t    out_q;
  logic        out_valid_q;

  assign w_opcode    = in_instr[31:26];
  assign w_rt        = in_instr[20:16];
  assign w_rd        = in_instr[15:11];
  assign w_shamt     = in_instr[10:6];
  assign w_funct     = in_instr[5:0];
  assign w_imm_sx    = {{16{in_instr[15]}}, in_instr[15:0]};
  assign w_imm_zx    = {16'd0, in_instr[15:0]};
  // The rs index is resolved upstream; only its value arrives here.
  assign w_unused_rs = ^in_instr[25:21];

  always_comb begin
    w_dec         = c_reset_pl;
    w_dec.illegal = 1'b1;
    case (w_opcode)
      6'h00: begin
        case (w_funct)
          6'h00, 6'h02, 6'h03: begin
            w_dec.a       = {27'd0, w_shamt};
            w_dec.b       = in_rt_val;
            w_dec.aluc    = w_funct;
            w_dec.dest    = w_rd;
            w_dec.illegal = 1'b0;
          end
          6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            w_dec.a       = in_rs_val;
            w_dec.b       = in_rt_val;
            w_dec.aluc    = w_funct;
            w_dec.dest    = w_rd;
            w_dec.illegal = 1'b0;
          end
          default: ;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        w_dec.a       = in_rs_val;
        w_dec.b       = w_imm_zx;
        w_dec.dest    = w_rt;
        w_dec.illegal = 1'b0;
        case (w_opcode)
          6'h08:   begin w_dec.aluc = 6'b100000; w_dec.b = w_imm_sx; end
          6'h09:   begin w_dec.aluc = 6'b100001; w_dec.b = w_imm_sx; end
          6'h0A:   begin w_dec.aluc = 6'b101010; w_dec.b = w_imm_sx; end
          6'h0B:   begin w_dec.aluc = 6'b101011; w_dec.b = w_imm_sx; end
          6'h0C:   w_dec.aluc = 6'b100100;
          6'h0D:   w_dec.aluc = 6'b100101;
          6'h0E:   w_dec.aluc = 6'b100110;
          default: begin w_dec.aluc = 6'b001111; w_dec.a = 32'd0; end
        endcase
      end
      default: ;
    endcase
    w_dec.wen = ~w_dec.illegal & (w_dec.dest != 5'd0);
  end

  // Flush discards whatever is offered in the same cycle.
  assign w_accept = in_valid & in_ready & ~flush;

  generate
    if (SKID != 0) begin : g_skid
      payload_t skid_q;
      logic     skid_valid_q;

      assign in_ready = ~skid_valid_q & ~rst;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q  <= 1'b0;
          out_q        <= c_reset_pl;
          skid_valid_q <= 1'b0;
          skid_q       <= c_reset_pl;
        end else if (flush) begin
          out_valid_q  <= 1'b0;
          skid_valid_q <= 1'b0;
        end else if (~out_valid_q | out_ready) begin
          // in_ready is low whenever the skid entry is occupied, so the two
          // branches below never both want the output register.
          if (skid_valid_q) begin
            out_q        <= skid_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
          end else begin
            out_valid_q <= w_accept;
            if (w_accept) begin
              out_q <= w_dec;
            end
          end
        end else if (w_accept) begin
          skid_q       <= w_dec;
          skid_valid_q <= 1'b1;
        end
      end
    end else begin : g_noskid
      assign in_ready = (~out_valid_q | out_ready) & ~rst;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          out_q       <= c_reset_pl;
        end else if (flush) begin
          out_valid_q <= 1'b0;
        end else if (~out_valid_q | out_ready) begin
          out_valid_q <= w_accept;
          if (w_accept) begin
            out_q <= w_dec;
          end
        end
      end
    end
  endgenerate

  assign out_valid   = out_valid_q;
  assign out_a       = out_q.a;
  assign out_b       = out_q.b;
  assign out_aluc    = out_q.aluc;
  assign out_dest    = out_q.dest;
  assign out_wen     = out_q.wen;
  assign out_illegal = out_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
// tb_alu_operand_stage : random + directed bench for both SKID variants
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_operand_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  aluc;
    logic [4:0]  dest;
    logic        wen;
    logic        illegal;
  } payload_t;

  localparam payload_t RST_PL = '{32'd0, 32'd0, 6'h21, 5'd0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_rs_val, in_rt_val;

  logic        o1_ready, o1_valid, o1_wen, o1_ill;
  logic [31:0] o1_a, o1_b;
  logic [5:0]  o1_aluc;
  logic [4:0]  o1_dest;
  logic        o0_ready, o0_valid, o0_wen, o0_ill;
  logic [31:0] o0_a, o0_b;
  logic [5:0]  o0_aluc;
  logic [4:0]  o0_dest;

  int n_total = 0;
  int n_bad   = 0;

  payload_t q1[$];
  payload_t q0[$];
  logic     fresh1, fresh0, acc1, acc0;

  always #5 clk = ~clk;

  alu_operand_stage #(.SKID(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o1_ready),
    .in_instr(in_instr), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .out_valid(o1_valid), .out_ready(out_ready), .out_a(o1_a), .out_b(o1_b),
    .out_aluc(o1_aluc), .out_dest(o1_dest), .out_wen(o1_wen), .out_illegal(o1_ill)
  );

  alu_operand_stage #(.SKID(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o0_ready),
    .in_instr(in_instr), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .out_valid(o0_valid), .out_ready(out_ready), .out_a(o0_a), .out_b(o0_b),
    .out_aluc(o0_aluc), .out_dest(o0_dest), .out_wen(o0_wen), .out_illegal(o0_ill)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set table.
  function automatic payload_t ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                          input logic [31:0] rt);
    payload_t    p;
    logic [5:0]  itab [8];
    logic [5:0]  op;
    logic [5:0]  fn;
    int          opn;
    itab = '{6'h20, 6'h21, 6'h2A, 6'h2B, 6'h24, 6'h25, 6'h26, 6'h0F};
    op   = ins[31:26];
    fn   = ins[5:0];
    opn  = int'(op);
    p    = '{32'd0, 32'd0, 6'h21, 5'd0, 1'b0, 1'b1};
    if (op == 6'd0) begin
      if (fn inside {6'h00, 6'h02, 6'h03}) begin
        p = '{32'(ins[10:6]), rt, fn, ins[15:11], 1'b0, 1'b0};
      end else if (fn inside {6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A, 6'h2B}) begin
        p = '{rs, rt, fn, ins[15:11], 1'b0, 1'b0};
      end
    end else if (opn >= 8 && opn <= 15) begin
      p.a       = (opn == 15) ? 32'd0 : rs;
      p.b       = (opn < 12) ? 32'($signed(ins[15:0])) : 32'(ins[15:0]);
      p.aluc    = itab[opn - 8];
      p.dest    = ins[20:16];
      p.illegal = 1'b0;
    end
    p.wen = !p.illegal && (p.dest != 5'd0);
    return p;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  rf [16];
    logic [31:0] w;
    int          k;
    rf = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
           6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    w  = $urandom;
    k  = $urandom_range(0, 9);
    if (k < 5) begin
      w[31:26] = 6'd0;
      if ($urandom_range(0, 7) != 0) w[5:0] = rf[$urandom_range(0, 15)];
    end else if (k < 9) begin
      w[31:26] = 6'($urandom_range(8, 15));
    end
    return w;
  endfunction

  task automatic check_dut(input string nm, input logic ov, input logic ev,
                           input logic orr, input logic er,
                           input payload_t op, input payload_t ep, input logic fields);
    chk({nm, ".valid"}, 32'(ov), 32'(ev));
    chk({nm, ".in_ready"}, 32'(orr), 32'(er));
    if (fields) begin
      chk({nm, ".a"}, op.a, ep.a);
      chk({nm, ".b"}, op.b, ep.b);
      chk({nm, ".aluc"}, 32'(op.aluc), 32'(ep.aluc));
      chk({nm, ".dest"}, 32'(op.dest), 32'(ep.dest));
      chk({nm, ".wen"}, 32'(op.wen), 32'(ep.wen));
      chk({nm, ".illegal"}, 32'(op.illegal), 32'(ep.illegal));
    end
  endtask

  // Inputs are already applied at the falling edge; check, advance the model,
  // then move to the next falling edge.
  task automatic tick();
    payload_t d, e1, e0;
    logic     r1, r0;
    #1;
    d  = ref_decode(in_instr, in_rs_val, in_rt_val);
    r1 = !rst && (q1.size() < 2);
    r0 = !rst && (q0.size() == 0 || out_ready);
    e1 = (q1.size() != 0) ? q1[0] : RST_PL;
    e0 = (q0.size() != 0) ? q0[0] : RST_PL;
    check_dut("skid1", o1_valid, q1.size() != 0, o1_ready, r1,
              '{o1_a, o1_b, o1_aluc, o1_dest, o1_wen, o1_ill}, e1,
              (q1.size() != 0) || fresh1);
    check_dut("skid0", o0_valid, q0.size() != 0, o0_ready, r0,
              '{o0_a, o0_b, o0_aluc, o0_dest, o0_wen, o0_ill}, e0,
              (q0.size() != 0) || fresh0);
    acc1 = in_valid && r1 && !flush;
    acc0 = in_valid && r0 && !flush;
    if (rst) begin
      q1.delete(); q0.delete(); fresh1 = 1'b1; fresh0 = 1'b1;
    end else if (flush) begin
      q1.delete(); q0.delete(); fresh1 = 1'b0; fresh0 = 1'b0;
    end else begin
      if (q1.size() != 0 && out_ready) void'(q1.pop_front());
      if (q0.size() != 0 && out_ready) void'(q0.pop_front());
      if (acc1) begin q1.push_back(d); fresh1 = 1'b0; end
      if (acc0) begin q0.push_back(d); fresh0 = 1'b0; end
    end
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    in_valid  = 1'b1;
    in_instr  = ins;
    in_rs_val = rs;
    in_rt_val = rt;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] seq [4];
    int          idx;
    int          cnt;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_rs_val = '0; in_rt_val = '0;
    fresh1 = 1'b1; fresh0 = 1'b1;
    repeat (2) @(negedge clk);
    tick();
    rst = 1'b0;

    // ADDI $t1,$t0,-1
    offer(32'h2109FFFF, 32'd5, $urandom);
    chk("addi.valid", 32'(o1_valid), 32'd1);
    chk("addi.aluc", 32'(o1_aluc), 32'h20);
    chk("addi.a", o1_a, 32'd5);
    chk("addi.b", o1_b, 32'hFFFFFFFF);
    chk("addi.dest", 32'(o1_dest), 32'd9);
    chk("addi.wen", 32'(o1_wen), 32'd1);

    // SRA $t2,$t3,4
    offer(32'h000B5103, $urandom, 32'h80000000);
    chk("sra.aluc", 32'(o1_aluc), 32'h03);
    chk("sra.a", o1_a, 32'd4);
    chk("sra.b", o1_b, 32'h80000000);
    chk("sra.dest", 32'(o1_dest), 32'd10);

    // ORI $5,$0,0x8000 must zero-extend
    offer(32'h34058000, $urandom, $urandom);
    chk("ori.b", o1_b, 32'h00008000);

    offer(32'h00000000, $urandom, $urandom);
    chk("nop.wen", 32'(o1_wen), 32'd0);
    chk("nop.illegal", 32'(o1_ill), 32'd0);

    offer(32'hFC221234, $urandom, $urandom);
    chk("op3f.illegal", 32'(o1_ill), 32'd1);
    chk("op3f.wen", 32'(o1_wen), 32'd0);
    chk("op3f.aluc", 32'(o1_aluc), 32'h21);
    chk("op3f.a", o1_a, 32'd0);
    chk("op3f.b", o1_b, 32'd0);
    offer(32'h01095018, $urandom, $urandom);
    chk("fn18.illegal", 32'(o1_ill), 32'd1);
    offer(32'h25280003, $urandom, $urandom);
    chk("addiu.illegal", 32'(o1_ill), 32'd0);
    repeat (2) tick();

    // Continuous stream with a two-cycle output stall
    seq = '{32'h2109FFFF, 32'h000B5103, 32'h34058000, 32'h01285020};
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c == 1 || c == 2);
      in_valid  = (idx < 4);
      in_instr  = seq[idx % 4];
      in_rs_val = $urandom;
      in_rt_val = $urandom;
      tick();
      if (acc1) idx++;
    end
    in_valid = 1'b0;
    chk("stall.sent", 32'(idx), 32'd4);

    // Flush with output and skid full while a third is offered
    out_ready = 1'b0;
    offer(rand_instr(), $urandom, $urandom);
    offer(rand_instr(), $urandom, $urandom);
    flush = 1'b1;
    offer(rand_instr(), $urandom, $urandom);
    flush = 1'b0;
    chk("flush.valid", 32'(o1_valid), 32'd0);
    chk("flush.in_ready", 32'(o1_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset in the middle of a stall
    out_ready = 1'b0;
    offer(rand_instr(), $urandom, $urandom);
    offer(rand_instr(), $urandom, $urandom);
    rst = 1'b1;
    offer(rand_instr(), $urandom, $urandom);
    rst = 1'b0;
    chk("rst.valid1", 32'(o1_valid), 32'd0);
    chk("rst.aluc1", 32'(o1_aluc), 32'h21);
    chk("rst.valid0", 32'(o0_valid), 32'd0);
    chk("rst.aluc0", 32'(o0_aluc), 32'h21);
    tick();

    // SKID=0 must sustain one transfer per cycle with out_ready high
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid  = 1'b1;
      in_instr  = rand_instr();
      in_rs_val = $urandom;
      in_rt_val = $urandom;
      tick();
      if (acc0) cnt++;
    end
    in_valid = 1'b0;
    chk("s0.stream", 32'(cnt), 32'd10);
    tick();

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      in_instr  = rand_instr();
      in_rs_val = $urandom;
      in_rt_val = $urandom;
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
